ahb_s2m_mux_p: RTL
==================

# ahb_s2m_mux_p

Parametrised AHB slave-to-master multiplexer for the bus matrix: routes read data and response of the slave owning the current data phase back to one master. It tracks the address→data phase pipeline with a registered select, idles with a zero-wait OKAY when no transfer is in flight, and flags illegal multi-hot decoder output. It can optionally include a built-in default slave that gives the two-cycle AHB ERROR response for unmapped accesses. It sits between the decoder/slave ports and one master port.

## Interface
Parameters:
- NUM_SLAVES, 8: slave ports, 2..16; slot 0 is the default-slave slot.
- DATA_WIDTH, 32: HRDATA width, 32 or 64.

Ports:
- HCLK  in  1  bus clock; one clock; all state on rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- HTRANS  in  2  master address-phase transfer type; bit 1 set = NONSEQ/SEQ.
- HSEL  in  NUM_SLAVES  decoder selects, one bit per slave, address phase.
- HRDATA_S  in  NUM_SLAVES*DATA_WIDTH  slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH].
- HREADY_S  in  NUM_SLAVES  slave HREADYOUT.
- HRESP_S  in  2*NUM_SLAVES  slave responses, slave i at [2i +: 2].
- HREADY  out  1  muxed ready to master and to all slaves.
- HRESP  out  2  muxed response: OKAY 00, ERROR 01, RETRY 10, SPLIT 11.
- HRDATA  out  DATA_WIDTH  muxed read data.
- sel_err  out  1  sticky: multi-hot HSEL sampled on an active transfer. Cleared only by reset.

## Operation
- State register `st` with values IDLE, SLV, ERR1 and ERR2. Select index `sel_q` is ceil(log2(NUM_SLAVES)) bits.
- Address sampling happens on a rising edge where HREADY=1:
  - HTRANS[1]=0: next state IDLE.
  - HTRANS[1]=1 and HSEL one-hot at bit k: next state SLV, sel_q=k.
  - HTRANS[1]=1 and HSEL zero or multi-hot: handled as set out under Configuration. Multi-hot also sets sel_err.
- When HREADY=0, the state holds, except that ERR1 always goes to ERR2.
- Outputs are combinational from `st`/`sel_q` and the slave inputs:
  - IDLE: HREADY=1, HRESP=00, HRDATA=0.
  - SLV: HREADY=HREADY_S[sel_q], HRESP=HRESP_S[sel_q], HRDATA=HRDATA_S[sel_q].
  - ERR1: HREADY=0, HRESP=01, HRDATA=0.
  - ERR2: HREADY=1, HRESP=01, HRDATA=0.
- In ERR2, HREADY=1, so the next address phase is sampled normally.
- Slave RETRY/SPLIT and multi-cycle ERROR are passed through unchanged, cycle by cycle.
- Reset values: st=IDLE, sel_q=0, sel_err=0. Outputs are therefore HREADY=1, HRESP=00, HRDATA=0.
- Reset asserted mid-transfer, including mid-ERR1: outputs go to reset values immediately (asynchronous reset). Any pending data phase is discarded.

## Timing
- Select latency is 1 cycle: the address phase is sampled at edge n and the data phase mux is valid after edge n.
- The mux adds zero wait states. Back-to-back transfers to different slaves switch select in the cycle after each HREADY=1 edge.
- Wait states: a slave driving HREADY_S low extends the data phase. The next address (HSEL/HTRANS) is ignored until HREADY=1.
- Internal error response is exactly 2 cycles: ERR1 (HREADY low) then ERR2 (HREADY high).
- Combinational path from HRDATA_S/HREADY_S/HRESP_S to the outputs is one mux level. There is no combinational path from HSEL/HTRANS to the outputs.

## Configuration
- AHB_S2M_DEFSLV_EN defined:
  - Unmapped or multi-hot active transfer goes to ERR1, producing the two-cycle ERROR.
  - Slot 0 inputs are ignored, and HSEL[0] is treated as unmapped.
- AHB_S2M_DEFSLV_EN undefined:
  - Zero or multi-hot active transfer goes to SLV with sel_q=0, so the external default slave on slot 0 responds.
  - ERR1/ERR2 are not compiled in.
- sel_err behaves the same in both builds.

## Structure
- Shared package `ahb_s2m_pkg`:
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ.
  - HRESP encodings OKAY/ERROR/RETRY/SPLIT.
  - State encoding constants for IDLE/SLV/ERR1/ERR2.
- Sub-module `ahb_s2m_onehot_enc`, parametrised by NUM_SLAVES:
  - Input: HSEL.
  - Outputs: `idx`, `one_hot`, `multi`.
  - Purely combinational and instantiated once.

## Test plan
- Reset, then HTRANS=IDLE for 3 cycles: HREADY=1, HRESP=00, HRDATA=0 throughout, sel_err=0.
- NONSEQ with HSEL=0x04, then slave 2 gives HREADY_S[2]=0 for 2 cycles and HRDATA_S slot 2=0xCAFEF00D: master sees 2 wait cycles, then 0xCAFEF00D with HREADY=1, HRESP=00.
- Back-to-back NONSEQ to slave 3 then slave 5 (zero-wait): HRDATA switches from slot 3 to slot 5 data on consecutive cycles with no bubble.
- With DEFSLV_EN, NONSEQ with HSEL=0: HREADY=0/HRESP=01, then HREADY=1/HRESP=01, then IDLE. Without DEFSLV_EN: slot 0 outputs appear.
- NONSEQ with HSEL=0x0A: sel_err rises and stays 1. Subsequent legal transfers still route correctly.
- Assert HRESETn low during ERR1 or during a slave wait state: outputs immediately return to HREADY=1, HRESP=00, HRDATA=0, and st=IDLE after release.

Source files
------------

// File: rtl/ahb_s2m_pkg.sv
// Shared encodings for the AHB slave-to-master multiplexer.
// Holds the HTRANS and HRESP codes, the mux state encoding and a helper
// that decodes whether an address phase carries a real transfer.
package ahb_s2m_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLV  = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } st_e;

  // NONSEQ and SEQ start a data phase; IDLE and BUSY never do.
  function automatic logic trans_active(input logic [1:0] htrans);
    return (htrans != HTRANS_IDLE) && (htrans != HTRANS_BUSY);
  endfunction

endpackage

// File: rtl/ahb_s2m_onehot_enc.sv
// One-hot to index encoder for the decoder HSEL vector.
// idx is only meaningful when one_hot is set; multi flags two or more bits.
module ahb_s2m_onehot_enc #(
  parameter int NUM_SLAVES = 8,
  parameter int IDX_W      = $clog2(NUM_SLAVES)
) (
  input  logic [NUM_SLAVES-1:0] hsel,
  output logic [IDX_W-1:0]      idx,
  output logic                  one_hot,
  output logic                  multi
);

  // Clearing the lowest set bit leaves something only when several are set.
  always_comb begin
    idx     = '0;
    multi   = |(hsel & (hsel - NUM_SLAVES'(1)));
    one_hot = (|hsel) && !multi;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (hsel[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ahb_s2m_mux_p.sv
// AHB slave-to-master multiplexer: routes HRDATA/HREADY/HRESP of the slave
// owning the current data phase back to the master.
// Optional build macro: AHB_S2M_DEFSLV_EN -- adds a built-in default slave
// that answers unmapped or multi-hot transfers with a two-cycle ERROR and
// ignores the slot-0 slave inputs. Without it, slot 0 is the external
// default slave and takes every unmapped or multi-hot transfer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no data phase in flight; zero-wait OKAY
// ST_SLV  | data phase owned by slave sel_q; its signals are muxed out
// ST_ERR1 | internal ERROR, first cycle (HREADY low)
// ST_ERR2 | internal ERROR, second cycle (HREADY high, next address sampled)
module ahb_s2m_mux_p #(
  parameter int NUM_SLAVES = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic [1:0]                       HTRANS,
  input  logic [NUM_SLAVES-1:0]            HSEL,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]            HREADY_S,
  input  logic [2*NUM_SLAVES-1:0]          HRESP_S,
  output logic                             HREADY,
  output logic [1:0]                       HRESP,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic                             sel_err
);
  import ahb_s2m_pkg::*;

  localparam int IDX_W = $clog2(NUM_SLAVES);

`ifdef AHB_S2M_DEFSLV_EN
  localparam int FIRST_SLOT = 1;
`else
  localparam int FIRST_SLOT = 0;
`endif

  st_e              st_q, st_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic             sel_err_q, sel_err_d;

  logic [IDX_W-1:0]      enc_idx;
  logic                  enc_one_hot;
  logic                  enc_multi;
  logic                  addr_active;
  logic                  addr_hit;

  logic                  slv_ready;
  logic [1:0]            slv_resp;
  logic [DATA_WIDTH-1:0] slv_data;

  logic                  hready_mux;
  logic [1:0]            hresp_mux;
  logic [DATA_WIDTH-1:0] hrdata_mux;

  ahb_s2m_onehot_enc #(
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W)
  ) u_enc (
    .hsel    (HSEL),
    .idx     (enc_idx),
    .one_hot (enc_one_hot),
    .multi   (enc_multi)
  );

  assign addr_active = trans_active(HTRANS);

`ifdef AHB_S2M_DEFSLV_EN
  // Slot 0 belongs to the internal default slave, so a select on it is unmapped.
  assign addr_hit = enc_one_hot && (enc_idx != '0);

  logic unused_slot0;
  assign unused_slot0 = ^{HREADY_S[0], HRESP_S[1:0], HRDATA_S[DATA_WIDTH-1:0]};
`else
  assign addr_hit = enc_one_hot;
`endif

  // State, select and sticky error registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      st_q      <= ST_IDLE;
      sel_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      sel_q     <= sel_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Next state: sample the address phase only on HREADY high edges.
  always_comb begin
    st_d      = st_q;
    sel_d     = sel_q;
    sel_err_d = sel_err_q;
    if (hready_mux) begin
      if (addr_active) begin
        if (enc_multi) begin
          sel_err_d = 1'b1;
        end
        if (addr_hit) begin
          st_d  = ST_SLV;
          sel_d = enc_idx;
        end else begin
`ifdef AHB_S2M_DEFSLV_EN
          st_d  = ST_ERR1;
`else
          st_d  = ST_SLV;
          sel_d = '0;
`endif
        end
      end else begin
        st_d = ST_IDLE;
      end
    end
`ifdef AHB_S2M_DEFSLV_EN
    else if (st_q == ST_ERR1) begin
      st_d = ST_ERR2;
    end
`endif
  end

  // Single-level slave mux keyed by the registered select.
  always_comb begin
    slv_ready = 1'b1;
    slv_resp  = HRESP_OKAY;
    slv_data  = '0;
    for (int i = FIRST_SLOT; i < NUM_SLAVES; i++) begin
      if (sel_q == IDX_W'(i)) begin
        slv_ready = HREADY_S[i];
        slv_resp  = HRESP_S[2*i +: 2];
        slv_data  = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Master-facing outputs depend only on state, select and slave inputs.
  always_comb begin
    hready_mux = 1'b1;
    hresp_mux  = HRESP_OKAY;
    hrdata_mux = '0;
    case (st_q)
      ST_SLV: begin
        hready_mux = slv_ready;
        hresp_mux  = slv_resp;
        hrdata_mux = slv_data;
      end
`ifdef AHB_S2M_DEFSLV_EN
      ST_ERR1: begin
        hready_mux = 1'b0;
        hresp_mux  = HRESP_ERROR;
      end
      ST_ERR2: begin
        hready_mux = 1'b1;
        hresp_mux  = HRESP_ERROR;
      end
`endif
      default: begin
        hready_mux = 1'b1;
        hresp_mux  = HRESP_OKAY;
        hrdata_mux = '0;
      end
    endcase
  end

  assign HREADY  = hready_mux;
  assign HRESP   = hresp_mux;
  assign HRDATA  = hrdata_mux;
  assign sel_err = sel_err_q;

endmodule
